// File: rtl/addsub_pkg.sv
// addsub_pkg: shared widths, opcode and FSM state type for the add/sub functional unit
package addsub_pkg;
  localparam int TAG_W = 3;
  localparam int DATA_W = 16;
  localparam int CDB_W = 19;
  localparam logic [2:0] OP_SUB = 3'b001;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational 16-bit add/subtract with optional signed overflow (ADDSUB_OVF_EN)
module addsub_core
  import addsub_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result
`ifdef ADDSUB_OVF_EN
  ,
  output logic              ovf
`endif
);
  assign result = sub ? a - b : a + b;
`ifdef ADDSUB_OVF_EN
  // overflow when the result sign differs from A while the effective operands share a sign
  assign ovf = (a[DATA_W-1] ^ result[DATA_W-1]) & ~(a[DATA_W-1] ^ b[DATA_W-1] ^ sub);
`endif
endmodule

// File: rtl/addsub_fu.sv
// addsub_fu: multi-cycle add/sub unit with dispatch handshake and CDB writeback; ADDSUB_OVF_EN adds ovf output
module addsub_fu
  import addsub_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              despacho,
  input  logic [DATA_W-1:0] Valor1,
  input  logic [DATA_W-1:0] Valor2,
  input  logic [2:0]        OP,
  input  logic [TAG_W-1:0]  ID_in,
  output logic              confirma,
  output logic              busy,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [CDB_W-1:0]  CDB_out
`ifdef ADDSUB_OVF_EN
  ,
  output logic              ovf
`endif
);
  state_t             state;
  logic [1:0]         cnt;
  logic [DATA_W-1:0]  a_q, b_q, res_q, res_d;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
`ifdef ADDSUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  addsub_core u_core (
    .a      (a_q),
    .b      (b_q),
    .sub    (op_q == OP_SUB),
    .result (res_d)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf    (ovf_d)
`endif
  );

  assign busy    = state != IDLE;
  assign cdb_req = state == WB;
  assign CDB_out = cdb_req ? {tag_q, res_q} : '0;
`ifdef ADDSUB_OVF_EN
  assign ovf     = cdb_req & ovf_q;
`endif

  // accept in IDLE, count down in EXEC, hold the bus word in WB until granted
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      confirma <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      res_q    <= '0;
`ifdef ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      confirma <= 1'b0;
      if (state == IDLE && despacho && ID_in != '0) begin
        state    <= EXEC;
        cnt      <= 2'(LATENCY - 1);
        confirma <= 1'b1;
        a_q      <= Valor1;
        b_q      <= Valor2;
        op_q     <= OP;
        tag_q    <= ID_in;
      end else if (state == EXEC) begin
        if (cnt == 2'd0) begin
          state <= WB;
          res_q <= res_d;
`ifdef ADDSUB_OVF_EN
          ovf_q <= ovf_d;
`endif
        end else
          cnt <= cnt - 2'd1;
      end else if (state == WB && cdb_grant)
        state <= IDLE;
    end
endmodule
